// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets, STATUS bit layout and the baud divisor helper.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic [1:0] UART_DATA_OFS   = 2'd0;
    localparam logic [1:0] UART_STATUS_OFS = 2'd2;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_IDLE_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_CNT_LSB   = 4;

    // Rounded clocks-per-bit so the bit period error stays within half a clock.
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with show-ahead output. Pushes while full and pops
// while empty are ignored, so callers need no extra guarding.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [7:0]    mem_q [DEPTH];
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == (PW + 1)'(0));
    assign count     = count_q;
    assign dout      = mem_q[rd_ptr_q];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= (PW + 1)'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter: IO-bus register interface, byte FIFO,
// baud counter and framing FSM driving a registered tx pin.
module uart_tx_io
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 23000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        uartclk,
    input  logic        uartrst,
    input  logic        uartcs,
    input  logic        uartwrite,
    input  logic        uartread,
    input  logic [1:0]  uartaddr,
    input  logic [15:0] uartwdata,
    output logic [15:0] uartrdata,
    output logic        tx,
    output logic        busy
);

    localparam int DIV = uart_div(CLK_FREQ_HZ, BAUD);
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int FW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_div_chk
        $error("uart_tx_io: baud divisor must be at least 2");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("uart_tx_io: FIFO_DEPTH must be a power of two in 2..16");
    end

    tx_state_e     state_q, state_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          overflow_q, overflow_d;

    logic          wr_data_s;
    logic          rd_status_s;
    logic          bit_end_s;
    logic          fifo_pop_s;
    logic [7:0]    fifo_dout_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [FW:0]   fifo_count_s;
    logic [3:0]    count4_s;
    logic [15:0]   status_s;
    logic          unused_wdata_s;

    assign wr_data_s      = uartcs & uartwrite & (uartaddr == UART_DATA_OFS);
    assign rd_status_s    = uartcs & uartread & (uartaddr == UART_STATUS_OFS);
    assign bit_end_s      = (baud_cnt_q == BAUD_LAST);
    assign count4_s       = 4'(fifo_count_s);
    assign unused_wdata_s = ^uartwdata[15:8];

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (uartclk),
        .rst   (uartrst),
        .push  (wr_data_s),
        .pop   (fifo_pop_s),
        .din   (uartwdata[7:0]),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Framing FSM; STOP pops straight into START so queued frames abut.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        fifo_pop_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = CW'(0);
                bit_idx_d  = 3'd0;
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    shift_d    = fifo_dout_s;
                    state_d    = ST_START;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    baud_cnt_d = CW'(0);
                    bit_idx_d  = 3'd0;
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_cnt_d = CW'(0);
                    shift_d    = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
                        state_d   = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    baud_cnt_d = CW'(0);
                    if (!fifo_empty_s) begin
                        fifo_pop_s = 1'b1;
                        shift_d    = fifo_dout_s;
                        state_d    = ST_START;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                baud_cnt_d = CW'(0);
                bit_idx_d  = 3'd0;
            end
        endcase
    end

    // Line level follows the current state one clock later, keeping tx glitch-free.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_IDLE:  tx_d = 1'b1;
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            ST_STOP:  tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    // Sticky overflow; a dropped write on the same edge beats a clearing read.
    always_comb begin
        overflow_d = overflow_q;
        if (wr_data_s && fifo_full_s) begin
            overflow_d = 1'b1;
        end else if (rd_status_s) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // STATUS word and combinational read mux.
    always_comb begin
        status_s                     = 16'h0000;
        status_s[STAT_FULL_BIT]      = fifo_full_s;
        status_s[STAT_EMPTY_BIT]     = fifo_empty_s;
        status_s[STAT_IDLE_BIT]      = (state_q == ST_IDLE) & fifo_empty_s;
        status_s[STAT_OVF_BIT]       = overflow_q;
        status_s[STAT_CNT_LSB +: 4]  = count4_s;
        uartrdata                    = 16'h0000;
        if (uartcs && uartread) begin
            case (uartaddr)
                UART_STATUS_OFS: uartrdata = status_s;
                default:         uartrdata = 16'h0000;
            endcase
        end else begin
            uartrdata = 16'h0000;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge uartclk) begin
        if (uartrst) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= CW'(0);
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx   = tx_q;
    assign busy = ~((state_q == ST_IDLE) & fifo_empty_s);

endmodule

// File: doc/uart_tx_io.md
Name: uart_tx_io

Overview:
- Memory-mapped UART transmitter for program output: CPU firmware writes bytes over the IO bus, the block serializes them as 8N1 on the board tx pin.
- Reverse direction of the UART program-download path, which only receives.
- Sits beside the LED and switch drivers. Selected by the UartCtrl chip-select from the memory/IO decoder; shares ioWrite/ioRead strobes, address low bits and the 16-bit write data bus.
- Holds a small FIFO so firmware can queue bytes without polling for every byte.

Parameters:
- CLK_FREQ_HZ, 23000000: uartclk frequency in Hz.
- BAUD, 115200: line rate.
- FIFO_DEPTH, 8: byte FIFO entries. Power of two, 2..16.

Ports:
- uartclk  in  1  CPU clock (cpu_clk). Everything is on the rising edge.
- uartrst  in  1  synchronous active-high reset, sampled on the uartclk rising edge.
- uartcs  in  1  chip select from the IO decoder.
- uartwrite  in  1  IO write strobe (ioWrite).
- uartread  in  1  IO read strobe (ioRead).
- uartaddr  in  2  address bits [1:0]: 0 = DATA, 2 = STATUS.
- uartwdata  in  16  write data. Only [7:0] is used.
- uartrdata  out  16  read data to the IO read mux.
- tx  out  1  serial line, idle high.
- busy  out  1  high when the FIFO is non-empty or the shifter is active.

Behaviour:
- One clock (uartclk). Reset is synchronous, active-high (uartrst).
- Reset values:
  - tx = 1, busy = 0, uartrdata = 0.
  - FIFO empty, pointers and count = 0, overflow = 0.
  - FSM = IDLE, baud counter = 0, bit index = 0.
  - Reset mid-frame aborts the frame: tx returns to 1 on the reset edge and FIFO contents are discarded.
- Divisor: DIV = (CLK_FREQ_HZ + BAUD/2) / BAUD. It is computed at elaboration and must be >= 2. The baud counter counts 0..DIV-1, and each bit lasts exactly DIV cycles.
- Write to DATA (uartcs & uartwrite & uartaddr==0):
  - Pushes uartwdata[7:0] at that edge.
  - If the FIFO is full, the byte is dropped and overflow is set (sticky).
  - A push while full is dropped even if a pop happens on the same edge.
- Writes to other addresses are ignored.
- Read, combinational (uartcs & uartread):
  - addr 2 returns {8'b0, count[3:0], overflow, idle, empty, full}. Bit 0 = full, bit 1 = empty, bit 2 = idle (FSM IDLE and FIFO empty), bit 3 = overflow, [7:4] = count.
  - addr 0 returns 0.
  - When not selected, the output is 0.
  - A STATUS read clears overflow at that edge, unless an overflowing write occurs on the same edge; the set wins.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: tx = 1. If the FIFO is non-empty, pop into the shift register and go to START. A byte pushed at edge N into an empty FIFO is popped at edge N+1, and tx is low from edge N+2.
  - START: tx = 0 for DIV cycles, then DATA with bit index 0.
  - DATA: tx = shift[0], LSB first. After DIV cycles, shift right and increment the index. After bit 7, go to STOP.
  - STOP: tx = 1 for DIV cycles. At the last cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap between back-to-back frames). Otherwise go to IDLE.
- tx is a registered output: no glitches, changes only at bit boundaries.
- A push and a pop on the same edge leave count unchanged, and both take effect. A simultaneous push and pop when full is not possible (see the write rule).
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1. Count saturates at FIFO_DEPTH through the full check and never wraps.
- busy = ~(FSM==IDLE & empty), registered or derived from registered state; reset value 0.

Decomposition:
- Shared package uart_pkg:
  - tx FSM state enum (IDLE/START/DATA/STOP).
  - Register offsets UART_DATA_OFS = 2'd0, UART_STATUS_OFS = 2'd2.
  - STATUS bit positions.
  - The DIV function.
- One natural sub-module: uart_tx_fifo, a synchronous byte FIFO with push, pop, dout, full, empty and count. The FSM, baud counter and bus interface live in uart_tx_io.

Test Plan:
All scenarios use CLK_FREQ_HZ=1000, BAUD=100 (DIV=10) and FIFO_DEPTH=4.
- Reset, then idle: tx=1, busy=0, STATUS read returns 0x0006 (empty, idle).
- Write 0x55 to DATA at edge N:
  - tx=0 over cycles N+2..N+11.
  - Then the bits 1,0,1,0,1,0,1,0, 10 cycles each.
  - Then stop=1 for 10 cycles.
  - busy falls after the stop bit, and STATUS returns 0x0006 afterwards.
- Write 0xA3, 0x0F, 0xFF back-to-back: three frames, each 100 cycles, with no idle cycle between stop and the next start. Decoded bytes arrive in order.
- Write 6 bytes in consecutive cycles while the first is transmitting:
  - 5 accepted: one enters the shifter, 4 go to the FIFO.
  - The 6th is dropped, and STATUS shows full=1, overflow=1, count=4.
  - A second STATUS read shows overflow=0.
  - Only 5 frames appear on tx.
- Assert uartrst in the middle of the DATA state of a frame: tx=1 on the next edge, FIFO empty, busy=0. No partial frame resumes, and a subsequent write of 0x81 transmits cleanly.
- Write 0x12 to address 1, and read DATA with cs high: no transmission, FIFO count stays 0, uartrdata=0. With cs low, uartrdata=0 even while uartread=1.
